// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mac_operand_feeder
// Purpose  : Producer side of the MAC operand interface. Buffers upstream
//            operand pairs in a small FIFO, groups them into dot-product
//            vectors of VEC_LEN terms, clears the MAC accumulator before each
//            vector and pulses vec_done when the vector result is valid.
// Options  : MAC_FEEDER_ZERO_SKIP_EN - pairs with a zero operand still count
//            as a term but do not raise mac_load (operands driven to zero).
// Revision : 1.0 - initial release
// ============================================================================
module mac_operand_feeder #(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 8,
    parameter int VEC_LEN = 4
) (
    input  logic                           sys_clock,
    input  logic                           sclr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_a,
    input  logic [DATA_W-1:0]              in_b,
    output logic [DATA_W-1:0]              mac_a,
    output logic [DATA_W-1:0]              mac_b,
    output logic                           mac_load,
    output logic                           mac_sclr,
    output logic                           vec_done,
    output logic [$clog2(VEC_LEN+1)-1:0]   term_cnt,
    output logic                           busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TC_W  = $clog2(VEC_LEN + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [TC_W-1:0]  TC_ONE    = TC_W'(1);
    localparam logic [TC_W-1:0]  LAST_TERM = TC_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FEED  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    logic [2*DATA_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [DATA_W-1:0]       head_a;
    logic [DATA_W-1:0]       head_b;
    logic                    skip;
    // Delays the completion pulse one cycle so it lines up with the MAC
    // register holding the final accumulated value.
    logic                    done_pend;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign in_ready   = (fifo_cnt != FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = in_valid && in_ready;
    assign pop        = (state == FEED) && !fifo_empty;
    assign head_a     = mem[rd_ptr][2*DATA_W-1:DATA_W];
    assign head_b     = mem[rd_ptr][DATA_W-1:0];
    assign busy       = (state != IDLE);

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    // A zero operand contributes nothing, so the load is suppressed.
    assign skip = (head_a == '0) || (head_b == '0);
`else
    assign skip = 1'b0;
`endif

    // FIFO storage write; contents need no reset since the count gates reads.
    always_ff @(posedge sys_clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge sys_clock) begin
        if (sclr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Vector sequencer with registered MAC-side outputs.
    always_ff @(posedge sys_clock) begin
        if (sclr) begin
            state     <= IDLE;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_load  <= 1'b0;
            mac_sclr  <= 1'b0;
            vec_done  <= 1'b0;
            done_pend <= 1'b0;
            term_cnt  <= '0;
        end else begin
            mac_load  <= 1'b0;
            mac_sclr  <= 1'b0;
            vec_done  <= done_pend;
            done_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    mac_sclr <= 1'b1;
                    term_cnt <= '0;
                    state    <= FEED;
                end
                FEED: begin
                    // An empty FIFO stalls here with operands held.
                    if (!fifo_empty) begin
                        term_cnt <= term_cnt + TC_ONE;
                        if (skip) begin
                            mac_a <= '0;
                            mac_b <= '0;
                        end else begin
                            mac_a    <= head_a;
                            mac_b    <= head_b;
                            mac_load <= 1'b1;
                        end
                        if (term_cnt == LAST_TERM) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_pend <= 1'b1;
                    state     <= fifo_empty ? IDLE : CLEAR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_operand_feeder
// Purpose  : Self-checking bench for mac_operand_feeder with a behavioural
//            MAC accumulator and operand/result scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_operand_feeder;

    localparam int DATA_W  = 4;
    localparam int DEPTH   = 8;
    localparam int VEC_LEN = 4;
    localparam int TC_W    = $clog2(VEC_LEN + 1);

    logic              clk = 1'b0;
    logic              sclr = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_load;
    logic              mac_sclr;
    logic              vec_done;
    logic [TC_W-1:0]   term_cnt;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    // scoreboard state
    logic [2*DATA_W-1:0] pair_q[$];
    logic [DATA_W-1:0]   sum_q[$];
    logic [DATA_W-1:0]   part_sum = '0;
    int                  part_n = 0;
    logic [DATA_W-1:0]   acc = '0;
    int                  model_cnt = 0;
    bit                  cnt_check_en = 0;
    bit                  saw_full = 0;
    bit                  push_timeout = 0;

    // event log
    int cyc = 0;
    int load_count, first_load, last_load;
    int sclr_count, sclr_cyc;
    int done_count, done_cyc;
    logic [DATA_W-1:0] done_acc;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .VEC_LEN (VEC_LEN)
    ) dut (
        .sys_clock (clk),
        .sclr      (sclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_load  (mac_load),
        .mac_sclr  (mac_sclr),
        .vec_done  (vec_done),
        .term_cnt  (term_cnt),
        .busy      (busy)
    );

    // Monitor: scoreboard, MAC model and FIFO-occupancy model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [2*DATA_W-1:0] p;
        cyc++;
        if (mac_load === 1'b1 && mac_sclr === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL load_sclr_overlap: both high at cycle %0d", cyc);
        end
        if (mac_load === 1'b1) begin
            load_count++;
            if (load_count == 1) first_load = cyc;
            last_load = cyc;
            model_cnt--;
`ifdef MAC_FEEDER_ZERO_SKIP_EN
            while (pair_q.size() > 0 &&
                   (pair_q[0][2*DATA_W-1:DATA_W] == '0 || pair_q[0][DATA_W-1:0] == '0))
                void'(pair_q.pop_front());
`endif
            checks++;
            if (pair_q.size() == 0) begin
                failures++;
                $display("FAIL operand_sb: load at cycle %0d with no expected pair", cyc);
            end else begin
                p = pair_q.pop_front();
                if ({mac_a, mac_b} !== p) begin
                    failures++;
                    $display("FAIL operand_sb: got a=%0d b=%0d expected a=%0d b=%0d",
                             mac_a, mac_b, p[2*DATA_W-1:DATA_W], p[DATA_W-1:0]);
                end
            end
        end
        if (mac_sclr === 1'b1) begin
            sclr_count++;
            sclr_cyc = cyc;
        end
        if (vec_done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
            done_acc = acc;
            checks++;
            if (sum_q.size() == 0) begin
                failures++;
                $display("FAIL result_sb: vec_done at cycle %0d with no expected vector", cyc);
            end else begin
                p[DATA_W-1:0] = sum_q.pop_front();
                if (acc !== p[DATA_W-1:0]) begin
                    failures++;
                    $display("FAIL result_sb: mac_out=%0d expected %0d", acc, p[DATA_W-1:0]);
                end
            end
        end
        if (cnt_check_en) begin
            checks++;
            if (in_ready !== (model_cnt != DEPTH)) begin
                failures++;
                $display("FAIL in_ready: got %b expected %b (occupancy %0d)",
                         in_ready, (model_cnt != DEPTH), model_cnt);
            end
        end
        if (in_ready === 1'b0) saw_full = 1;
        // behavioural MAC accumulator (wraps at DATA_W bits)
        if (mac_sclr === 1'b1) acc = '0;
        else if (mac_load === 1'b1) acc = acc + mac_a * mac_b;
        if (sclr) begin
            pair_q.delete();
            sum_q.delete();
            part_sum  = '0;
            part_n    = 0;
            model_cnt = 0;
        end else if (in_valid && in_ready === 1'b1) begin
            pair_q.push_back({in_a, in_b});
            model_cnt++;
            part_sum = part_sum + in_a * in_b;
            part_n++;
            if (part_n == VEC_LEN) begin
                sum_q.push_back(part_sum);
                part_sum = '0;
                part_n   = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        load_count = 0; first_load = 0; last_load = 0;
        sclr_count = 0; sclr_cyc = 0;
        done_count = 0; done_cyc = 0; done_acc = '0;
        push_timeout = 0;
    endtask

    // Presents one pair and holds it until accepted; ends at posedge+1.
    task automatic push_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i == 199) push_timeout = 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy && !vec_done && pair_q.size() == 0 && sum_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        sclr = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mac_a, mac_b, term_cnt, mac_load, mac_sclr, vec_done, busy, in_ready} !==
            {{2*DATA_W{1'b0}}, {TC_W{1'b0}}, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: a=%0d b=%0d tc=%0d ld=%b sc=%b vd=%b busy=%b rdy=%b expected zeros with rdy=1",
                     mac_a, mac_b, term_cnt, mac_load, mac_sclr, vec_done, busy, in_ready);
        end
        tick();
        sclr = 1'b0;
        cnt_check_en = 1;
    endtask

    task automatic test_single_vector();
        bit ok;
        clear_log();
        push_pair(4'd1, 4'd2);
        push_pair(4'd3, 4'd4);
        push_pair(4'd5, 4'd6);
        push_pair(4'd7, 4'd8);
        wait_idle(100, ok);
        checks++;
        if (!ok || push_timeout) begin failures++; $display("FAIL single_timeout: ok=%b push_to=%b", ok, push_timeout); end
        checks++;
        if (sclr_count != 1) begin failures++; $display("FAIL single_sclr_count: got %0d expected 1", sclr_count); end
        checks++;
        if (load_count != 4) begin failures++; $display("FAIL single_load_count: got %0d expected 4", load_count); end
        checks++;
        if (first_load != sclr_cyc + 1) begin failures++; $display("FAIL single_first_load: got %0d expected %0d", first_load, sclr_cyc + 1); end
        checks++;
        if (last_load != first_load + 3) begin failures++; $display("FAIL single_consecutive: got %0d expected %0d", last_load, first_load + 3); end
        checks++;
        if (done_count != 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", done_count); end
        checks++;
        if (done_cyc != last_load + 2) begin failures++; $display("FAIL single_done_latency: got %0d expected %0d", done_cyc, last_load + 2); end
        checks++;
        if (done_acc !== 4'd4) begin failures++; $display("FAIL single_mac_out: got %0d expected 4", done_acc); end
    endtask

    task automatic test_fifo_full();
        bit ok;
        clear_log();
        saw_full = 0;
        for (int i = 0; i < 28; i++)
            push_pair(4'((i % 15) + 1), 4'(((i + 5) % 15) + 1));
        wait_idle(300, ok);
        checks++;
        if (!ok || push_timeout) begin failures++; $display("FAIL full_timeout: ok=%b push_to=%b", ok, push_timeout); end
        checks++;
        if (!saw_full) begin failures++; $display("FAIL full_seen: got 0 expected 1"); end
        checks++;
        if (load_count != 28) begin failures++; $display("FAIL full_load_count: got %0d expected 28", load_count); end
        checks++;
        if (done_count != 7) begin failures++; $display("FAIL full_done_count: got %0d expected 7", done_count); end
        checks++;
        if (sclr_count != 7) begin failures++; $display("FAIL full_sclr_count: got %0d expected 7", sclr_count); end
    endtask

    task automatic test_gap_stall();
        bit ok;
        clear_log();
        push_pair(4'd2, 4'd3);
        push_pair(4'd1, 4'd4);
        repeat (5) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (mac_load !== 1'b0 || term_cnt !== TC_W'(2) || busy !== 1'b1) begin
                failures++;
                $display("FAIL gap_hold: ld=%b tc=%0d busy=%b expected ld=0 tc=2 busy=1", mac_load, term_cnt, busy);
            end
        end
        tick();
        push_pair(4'd3, 4'd3);
        push_pair(4'd2, 4'd2);
        wait_idle(100, ok);
        checks++;
        if (!ok || push_timeout) begin failures++; $display("FAIL gap_timeout: ok=%b push_to=%b", ok, push_timeout); end
        checks++;
        if (done_count != 1 || sclr_count != 1 || load_count != 4) begin
            failures++;
            $display("FAIL gap_counts: done=%0d sclr=%0d loads=%0d expected 1 1 4", done_count, sclr_count, load_count);
        end
        checks++;
        if (done_acc !== 4'd7) begin failures++; $display("FAIL gap_mac_out: got %0d expected 7", done_acc); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_log();
        for (int i = 0; i < 8; i++) push_pair(4'd1, 4'd1);
        wait_idle(100, ok);
        checks++;
        if (!ok || push_timeout) begin failures++; $display("FAIL b2b_timeout: ok=%b push_to=%b", ok, push_timeout); end
        checks++;
        if (sclr_count != 2 || done_count != 2 || load_count != 8) begin
            failures++;
            $display("FAIL b2b_counts: sclr=%0d done=%0d loads=%0d expected 2 2 8", sclr_count, done_count, load_count);
        end
        checks++;
        if (done_acc !== 4'd4) begin failures++; $display("FAIL b2b_mac_out: got %0d expected 4", done_acc); end
    endtask

    task automatic test_mid_reset();
        bit reached;
        clear_log();
        push_pair(4'd3, 4'd5);
        push_pair(4'd6, 4'd7);
        reached = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (term_cnt === TC_W'(2)) begin reached = 1; break; end
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL midrst_reach: term_cnt=%0d expected 2", term_cnt); end
        tick();
        push_pair(4'd9, 4'd9);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mac_a, mac_b, term_cnt, mac_load, mac_sclr, vec_done, busy, in_ready} !==
            {{2*DATA_W{1'b0}}, {TC_W{1'b0}}, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL midrst_state: a=%0d b=%0d tc=%0d ld=%b sc=%b vd=%b busy=%b rdy=%b expected zeros with rdy=1",
                     mac_a, mac_b, term_cnt, mac_load, mac_sclr, vec_done, busy, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || vec_done !== 1'b0) begin
                failures++;
                $display("FAIL midrst_flushed: busy=%b vd=%b expected 0 0", busy, vec_done);
            end
        end
        tick();
        checks++;
        if (done_count != 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", done_count); end
    endtask

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    task automatic test_zero_skip();
        bit ok;
        cnt_check_en = 0;
        clear_log();
        push_pair(4'd0, 4'd5);
        push_pair(4'd2, 4'd3);
        push_pair(4'd4, 4'd0);
        push_pair(4'd1, 4'd1);
        wait_idle(100, ok);
        checks++;
        if (!ok || push_timeout) begin failures++; $display("FAIL zs_timeout: ok=%b push_to=%b", ok, push_timeout); end
        checks++;
        if (load_count != 2) begin failures++; $display("FAIL zs_load_count: got %0d expected 2", load_count); end
        checks++;
        if (first_load != sclr_cyc + 2 || last_load != sclr_cyc + 4) begin
            failures++;
            $display("FAIL zs_load_pos: got %0d,%0d expected %0d,%0d", first_load, last_load, sclr_cyc + 2, sclr_cyc + 4);
        end
        checks++;
        if (done_count != 1) begin failures++; $display("FAIL zs_done_count: got %0d expected 1", done_count); end
        checks++;
        if (done_acc !== 4'd7) begin failures++; $display("FAIL zs_mac_out: got %0d expected 7", done_acc); end
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_single_vector();
        test_fifo_full();
        test_gap_stall();
        test_back_to_back();
        test_mid_reset();
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        test_zero_skip();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
